// File: rtl/elastic_pipeliner_if.sv
// Valid/ready bus around the elastic pipeliner: upstream beat in, downstream beat out.
// The slave view belongs to the pipeliner, the master view to whatever drives both ends.
interface elastic_pipeliner_if #(
  parameter int DATA_BIT_SIZE = 32
);
  logic [DATA_BIT_SIZE-1:0] data_in;
  logic                     valid_in;
  logic                     ready_out;
  logic [DATA_BIT_SIZE-1:0] data_out;
  logic                     valid_out;
  logic                     ready_in;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
  );
endinterface

// File: rtl/elastic_pipeliner.sv
// Elastic valid/ready delay line: N registered stages with bubble collapse,
// synchronous flush and a registered occupancy count.
module elastic_pipeliner #(
  parameter  int PIPELINE_STAGE_COUNT = 4,
  parameter  int DATA_BIT_SIZE        = 32,
  localparam int OCC_W                = $clog2(PIPELINE_STAGE_COUNT + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     flush_in,
  elastic_pipeliner_if.slave       bus,
  output logic [OCC_W-1:0]         occupancy_out
);
  localparam int N = PIPELINE_STAGE_COUNT;

  logic [N-1:0]             v_q, v_d;
  logic [DATA_BIT_SIZE-1:0] d_q [N];
  logic [DATA_BIT_SIZE-1:0] d_d [N];
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [N-1:0]             stage_rdy;

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic acc;
    acc       = bus.ready_in;
    stage_rdy = '0;
    for (int i = N - 1; i >= 0; i--) begin
      acc          = acc | ~v_q[i];
      stage_rdy[i] = acc;
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < N; i++) d_d[i] = d_q[i];
    if (stage_rdy[0]) begin
      v_d[0] = bus.valid_in;
      if (bus.valid_in && !flush_in) d_d[0] = bus.data_in;
    end
    for (int i = 1; i < N; i++) begin
      if (stage_rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1] && !flush_in) d_d[i] = d_q[i-1];
      end
    end
    if (flush_in) v_d = '0;
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N; i++) occ_d = occ_d + OCC_W'(v_d[i]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_q   <= '0;
      occ_q <= '0;
      d_q   <= '{default: '0};
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

  assign bus.ready_out  = stage_rdy[0] & rst_n_in;
  assign bus.valid_out  = v_q[N-1];
  assign bus.data_out   = d_q[N-1];
  assign occupancy_out  = occ_q;
endmodule

// File: tb/tb_elastic_pipeliner.sv
// Directed bench for elastic_pipeliner: a 4-stage instance for reset, streaming,
// stall/collapse, flush and mid-stall reset, plus a 1-stage instance under random backpressure.
module tb_elastic_pipeliner;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush4, flush1;
  logic [2:0] occ4;
  logic [0:0] occ1;

  elastic_pipeliner_if #(.DATA_BIT_SIZE(DW)) bus4 ();
  elastic_pipeliner_if #(.DATA_BIT_SIZE(DW)) bus1 ();

  elastic_pipeliner #(.PIPELINE_STAGE_COUNT(4), .DATA_BIT_SIZE(DW)) u_dut4 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .flush_in      (flush4),
    .bus           (bus4),
    .occupancy_out (occ4)
  );

  elastic_pipeliner #(.PIPELINE_STAGE_COUNT(1), .DATA_BIT_SIZE(DW)) u_dut1 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .flush_in      (flush1),
    .bus           (bus1),
    .occupancy_out (occ1)
  );

  // Stall/collapse vectors: input per edge and the hand-derived state after that edge.
  localparam logic       ST_V    [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
  localparam logic [7:0] ST_D    [8] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h04, 8'h05, 8'h05};
  localparam logic [2:0] ST_OCC  [8] = '{1, 1, 2, 2, 3, 4, 4, 4};
  localparam logic       ST_VOUT [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
  localparam logic       ST_RDY  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  localparam logic [7:0] DR_D    [4] = '{8'h02, 8'h03, 8'h04, 8'h00};
  localparam logic       DR_V    [4] = '{1, 1, 1, 0};
  localparam logic [2:0] DR_OCC  [4] = '{3, 2, 1, 0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       hold_pending;
    logic [7:0] held;
    logic       in_acc;
    int         exp_out;
    int         n_in;

    rst_n          = 1'b0;
    flush4         = 1'b0;
    flush1         = 1'b0;
    bus4.valid_in  = 1'b1;
    bus4.data_in   = 8'hA5;
    bus4.ready_in  = 1'b1;
    bus1.valid_in  = 1'b0;
    bus1.data_in   = 8'h00;
    bus1.ready_in  = 1'b0;

    // Reset held with a beat presented
    repeat (3) begin
      @(negedge clk);
      check("rst_valid_out", 32'(bus4.valid_out), 0);
      check("rst_ready_out", 32'(bus4.ready_out), 0);
      check("rst_occ", 32'(occ4), 0);
      check("rst_data_out", 32'(bus4.data_out), 0);
    end
    rst_n         = 1'b1;
    bus4.valid_in = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus4.ready_out), 1);
    check("post_rst_valid", 32'(bus4.valid_out), 0);

    // Streaming 0x01..0x10 with ready_in high
    for (int j = 1; j <= 21; j++) begin
      bus4.valid_in = (j <= 16);
      bus4.data_in  = 8'(j);
      @(negedge clk);
      check($sformatf("stream_valid_%0d", j), 32'(bus4.valid_out), 32'(j >= 4 && j <= 19));
      if (j >= 4 && j <= 19)
        check($sformatf("stream_data_%0d", j), 32'(bus4.data_out), 32'(j - 3));
      check($sformatf("stream_occ_%0d", j), 32'(occ4),
            32'((j <= 16) ? ((j < 4) ? j : 4) : ((j <= 20) ? 20 - j : 0)));
      check($sformatf("stream_ready_%0d", j), 32'(bus4.ready_out), 1);
    end

    // Stall with bubbles: beats compact, then drain in order
    bus4.ready_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bus4.valid_in = ST_V[j];
      bus4.data_in  = ST_D[j];
      @(negedge clk);
      check($sformatf("stall_occ_%0d", j), 32'(occ4), 32'(ST_OCC[j]));
      check($sformatf("stall_valid_%0d", j), 32'(bus4.valid_out), 32'(ST_VOUT[j]));
      check($sformatf("stall_ready_%0d", j), 32'(bus4.ready_out), 32'(ST_RDY[j]));
      if (ST_VOUT[j])
        check($sformatf("stall_data_%0d", j), 32'(bus4.data_out), 32'h01);
    end
    bus4.valid_in = 1'b0;
    bus4.ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drain_valid_%0d", k), 32'(bus4.valid_out), 32'(DR_V[k]));
      if (DR_V[k]) check($sformatf("drain_data_%0d", k), 32'(bus4.data_out), 32'(DR_D[k]));
      check($sformatf("drain_occ_%0d", k), 32'(occ4), 32'(DR_OCC[k]));
    end

    // Flush with three beats in flight and a beat presented in the flush cycle
    for (int j = 0; j < 3; j++) begin
      bus4.valid_in = 1'b1;
      bus4.data_in  = 8'(8'h11 + j);
      @(negedge clk);
    end
    check("pre_flush_occ", 32'(occ4), 3);
    check("pre_flush_valid", 32'(bus4.valid_out), 0);
    flush4       = 1'b1;
    bus4.data_in = 8'hFF;
    @(negedge clk);
    check("flush_occ", 32'(occ4), 0);
    check("flush_valid", 32'(bus4.valid_out), 0);
    check("flush_data_kept", 32'(bus4.data_out), 32'h04);
    check("flush_ready", 32'(bus4.ready_out), 1);
    flush4        = 1'b0;
    bus4.valid_in = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_flush_valid", 32'(bus4.valid_out), 0);
      check("post_flush_occ", 32'(occ4), 0);
    end

    // Fill under stall, then asynchronous reset between edges
    bus4.ready_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus4.valid_in = 1'b1;
      bus4.data_in  = 8'(8'h21 + j);
      @(negedge clk);
    end
    bus4.valid_in = 1'b0;
    check("full_occ", 32'(occ4), 4);
    check("full_ready", 32'(bus4.ready_out), 0);
    check("full_valid", 32'(bus4.valid_out), 1);
    check("full_data", 32'(bus4.data_out), 32'h21);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus4.valid_out), 0);
    check("async_rst_occ", 32'(occ4), 0);
    check("async_rst_ready", 32'(bus4.ready_out), 0);
    check("async_rst_data", 32'(bus4.data_out), 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus4.ready_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_async_valid", 32'(bus4.valid_out), 0);
      check("post_async_occ", 32'(occ4), 0);
    end

    // Single stage under random backpressure with continuous input
    bus1.valid_in = 1'b1;
    bus1.data_in  = 8'h01;
    exp_out       = 1;
    n_in          = 0;
    hold_pending  = 1'b0;
    held          = 8'h00;
    for (int c = 0; c < 60; c++) begin
      if (hold_pending) begin
        check("n1_hold_valid", 32'(bus1.valid_out), 1);
        check("n1_hold_data", 32'(bus1.data_out), 32'(held));
      end
      bus1.ready_in = 1'($urandom_range(0, 1));
      #1;
      if (bus1.valid_out && bus1.ready_in) begin
        check("n1_order", 32'(bus1.data_out), 32'(exp_out));
        exp_out++;
      end
      hold_pending = bus1.valid_out && !bus1.ready_in;
      held         = bus1.data_out;
      in_acc       = bus1.ready_out;
      @(posedge clk);
      #1;
      if (in_acc) begin
        bus1.data_in = bus1.data_in + 8'd1;
        n_in++;
      end
      @(negedge clk);
    end
    check("n1_occ_balance", 32'(occ1), 32'(n_in - (exp_out - 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/elastic_pipeliner.md
# elastic_pipeliner

Parametrised valid/ready delay line: a successor to the fixed register pipeline used between the datapath's multi-cycle arithmetic stages (modular multiply/exponentiate chains). It carries `DATA_BIT_SIZE`-bit words through `PIPELINE_STAGE_COUNT` registered stages with per-stage valid bits and backpressure. Idle stages absorb stalls (bubble collapse), a synchronous flush discards in-flight data, and an occupancy count is reported. Typical placement is between a producer that can stall and a consumer that asserts `ready_in`.

## Interface
- `PIPELINE_STAGE_COUNT`, default 4: number of register stages; must be ≥1.
- `DATA_BIT_SIZE`, default 32: payload width; must be ≥1.
- `clk_in` input, 1 bit: sole clock; all state updates on its rising edge.
- `rst_n_in` input, 1 bit: reset; asynchronous, active-low.
- `flush_in` input, 1 bit: synchronous flush of all stages.
- `data_in` input, `DATA_BIT_SIZE` bits: upstream payload.
- `valid_in` input, 1 bit: upstream beat present.
- `ready_out` output, 1 bit: pipeline accepts a beat this cycle.
- `data_out` output, `DATA_BIT_SIZE` bits: payload of the last stage.
- `valid_out` output, 1 bit: last stage holds a beat.
- `ready_in` input, 1 bit: downstream accepts a beat this cycle.
- `occupancy_out` output, `$clog2(PIPELINE_STAGE_COUNT+1)` bits: number of valid stages.

## Operation
- **Stage state:** stage i holds `v[i]` and `d[i]`. Stage 0 is fed from the input; stage N-1 (N = `PIPELINE_STAGE_COUNT`) drives `data_out`/`valid_out`.
- **Ready chain (combinational):**
  - `r[N-1] = ready_in | ~v[N-1]`.
  - `r[i] = r[i+1] | ~v[i]` for i < N-1.
  - `ready_out = r[0] & rst_n_in`.
- **Load rule:** when `r[i]` is high, `v[i] <= v[i-1]` (or `valid_in` for i=0).
  - `d[i]` loads `d[i-1]` (or `data_in`) only when the incoming valid is 1. Otherwise `d[i]` holds.
- **Stage hold:** when `r[i]` is low, stage i holds both `v[i]` and `d[i]`.
- **Transfers:**
  - Input transfer: `valid_in & ready_out`.
  - Output transfer: `valid_out & ready_in`.
- **Ordering:** beats are never reordered, duplicated or dropped, except by flush or reset.
- **Bubble collapse:** under a downstream stall, upstream beats keep advancing into empty stages until every stage is valid. `ready_out` falls only when all N stages are valid and `ready_in` is 0.
- **Flush:**
  - `flush_in` high at an edge clears all `v[i]` to 0; `d[i]` is unchanged.
  - A beat that satisfies the input handshake in a flush cycle is accepted but discarded.
  - An output transfer in a flush cycle completes normally; it is the downstream's choice to consume it.
  - Flush takes priority over loading.
- **Occupancy:** `occupancy_out` is a registered popcount of the next-state `v`, so it always equals the popcount of the current `v`.
- **Output stability:** while `valid_out & ~ready_in`, `data_out` and `valid_out` hold. This follows from `r[N-1]` being 0.
- **Width rules:** data passes bit-exact, with no arithmetic on the payload. `occupancy_out` ranges 0..N.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n_in` low):
  - all `v` = 0 and all `d` = 0.
  - `valid_out` = 0, `data_out` = 0, `occupancy_out` = 0.
  - `ready_out` = 0 while `rst_n_in` is low.
  - First `ready_out` = 1 in the cycle after deassertion.
- **Reset mid-operation:** all in-flight beats are lost and nothing is emitted afterward.
- **Latency:** a beat accepted at edge k appears with `valid_out`=1 after edge k+N-1, i.e. N cycles from presentation to output. This holds when it enters an empty pipeline and `ready_in` has stayed 1.
- **Throughput:** 1 beat/cycle sustained when `ready_in` is continuously 1.
- **Combinational paths:** `ready_in` → `ready_out` is combinational through N OR gates. No combinational path from `valid_in`/`data_in` to the outputs.
- **N=1:** single stage; `ready_out = ready_in | ~valid_out`. Simultaneous accept and emit is allowed.

## Test plan
- **Reset:** hold `rst_n_in`=0 for 3 cycles with `valid_in`=1 and `data_in`=0xA5 → `valid_out`=0, `ready_out`=0, `occupancy_out`=0. One cycle after release, `ready_out`=1.
- **Streaming (N=4, `ready_in`=1):** feed 0x1..0x10 back-to-back → `valid_out` first rises 4 cycles after 0x1 is presented, then 16 consecutive beats in order. `ready_out` stays 1 and `occupancy_out` reaches 4.
- **Stall and collapse:** send 0x1, bubble, 0x2, bubble, 0x3, then `ready_in`=0 → beats compact, `occupancy_out`=4 after the 4th beat and `ready_out`=0. Data holds stable. Releasing `ready_in` delivers 0x1,0x2,0x3,0x4 on consecutive cycles.
- **Flush:** with 3 beats in flight, pulse `flush_in` together with an input beat 0xFF → next cycle `occupancy_out`=0 and `valid_out`=0. 0xFF never appears.
- **Reset mid-stall:** fill all stages, assert `rst_n_in` low asynchronously between edges → `valid_out` drops immediately and no pre-reset beat ever emerges.
- **N=1 variant:** `ready_in` toggled randomly with continuous input → the output sequence equals the input sequence. No beat changes while `valid_out & ~ready_in`.
